// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: branch-type encodings, PC defaults, next-PC FSM states.
package mips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BR_TYPE_W = 3;

  localparam logic [BR_TYPE_W-1:0] BR_NONE = 3'b000;
  localparam logic [BR_TYPE_W-1:0] BR_BEQ  = 3'b001;
  localparam logic [BR_TYPE_W-1:0] BR_BNE  = 3'b010;
  localparam logic [BR_TYPE_W-1:0] BR_J    = 3'b011;
  localparam logic [BR_TYPE_W-1:0] BR_JAL  = 3'b100;
  localparam logic [BR_TYPE_W-1:0] BR_JR   = 3'b101;

  localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0000_4180;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  // Word-scaled sign-extended branch displacement.
  function automatic logic [XLEN-1:0] branch_disp(input logic [15:0] imm);
    branch_disp = {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_target.sv
// Branch/jump resolution: taken decision and target address for the EX-stage transfer.
// MISALIGN_CHECK_EN: misaligned jr targets are replaced by EXC_VECTOR and flagged.
module npc_target
  import mips_pkg::*;
#(
`ifdef MISALIGN_CHECK_EN
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
  input  logic [2:0]  br_type,
  input  logic [31:0] br_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  input  logic        alu_zero,
  output logic        taken_c,
  output logic [31:0] target_c,
  output logic        misalign_c
);

  logic [31:0] br_pc_plus4;

  assign br_pc_plus4 = br_pc + 32'(4);

  always_comb begin
    taken_c    = 1'b0;
    target_c   = br_pc_plus4;
    misalign_c = 1'b0;
    case (br_type)
      BR_BEQ: begin
        taken_c  = alu_zero;
        target_c = br_pc_plus4 + branch_disp(imm16);
      end
      BR_BNE: begin
        taken_c  = ~alu_zero;
        target_c = br_pc_plus4 + branch_disp(imm16);
      end
      BR_J, BR_JAL: begin
        taken_c  = 1'b1;
        target_c = {br_pc_plus4[31:28], instr_index, 2'b00};
      end
      BR_JR: begin
        taken_c  = 1'b1;
`ifdef MISALIGN_CHECK_EN
        if (rs_val[1:0] != 2'b00) begin
          target_c   = EXC_VECTOR;
          misalign_c = 1'b1;
        end else begin
          target_c   = rs_val;
        end
`else
        target_c = rs_val & 32'hFFFF_FFFC;
`endif
      end
      default: begin
        taken_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/npc_pc_unit.sv
// Program counter and next-PC unit; holds one resolved redirect while IF is stalled.
// MISALIGN_CHECK_EN enables the misaligned-jr exception redirect and misalign pulse.
module npc_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef MISALIGN_CHECK_EN
  ,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [2:0]  br_type,
  input  logic [31:0] br_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] link_addr,
  output logic        redirect,
  output logic        misalign
);

  logic        state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        taken_c;
  logic [31:0] target_c;
  logic        misalign_c;
  logic        redirect_c;

  npc_target
`ifdef MISALIGN_CHECK_EN
    #(.EXC_VECTOR(EXC_VECTOR))
`endif
  u_target (
    .br_type     (br_type),
    .br_pc       (br_pc),
    .imm16       (imm16),
    .instr_index (instr_index),
    .rs_val      (rs_val),
    .alu_zero    (alu_zero),
    .taken_c     (taken_c),
    .target_c    (target_c),
    .misalign_c  (misalign_c)
  );

  // Next-state / next-PC logic; transfers resolving in PENDING belong to flushed instructions.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    redirect_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid && taken_c) begin
          redirect_c = 1'b1;
          if (stall) begin
            pend_pc_d = target_c;
            state_d   = ST_PENDING;
          end else begin
            pc_d = target_c;
          end
        end else if (!stall) begin
          pc_d = pc_q + 32'(4);
        end
      end
      ST_PENDING: begin
        if (!stall) begin
          pc_d    = pend_pc_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'(4);
  assign link_addr = br_pc + 32'(8);
  assign redirect  = redirect_c & ~reset;
  assign misalign  = misalign_c & redirect;

endmodule

// File: tb/tb_npc_pc_unit.sv
// Directed table-driven bench for npc_pc_unit, plus a hand sequence for the jr alignment case.
module tb_npc_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, br_valid, alu_zero;
  logic [2:0]  br_type;
  logic [31:0] br_pc, rs_val;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] pc, pc_plus4, link_addr;
  logic        redirect, misalign;

  int checks   = 0;
  int failures = 0;

  npc_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_type(br_type),
    .br_pc(br_pc), .imm16(imm16), .instr_index(instr_index), .rs_val(rs_val),
    .alu_zero(alu_zero), .pc(pc), .pc_plus4(pc_plus4), .link_addr(link_addr),
    .redirect(redirect), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        vld;
    logic [2:0]  typ;
    logic [31:0] bpc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic        zero;
    logic [31:0] exp_pc;
    logic        exp_redir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic vld,
                              input logic [2:0] typ, input logic [31:0] bpc,
                              input logic [15:0] imm, input logic [25:0] idx,
                              input logic [31:0] rs, input logic zero,
                              input logic [31:0] exp_pc, input logic exp_redir);
    vec_t v;
    v.rst = rst; v.stl = stl; v.vld = vld; v.typ = typ; v.bpc = bpc; v.imm = imm;
    v.idx = idx; v.rs = rs; v.zero = zero; v.exp_pc = exp_pc; v.exp_redir = exp_redir;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; stall = v.stl; br_valid = v.vld; br_type = v.typ; br_pc = v.bpc;
    imm16 = v.imm; instr_index = v.idx; rs_val = v.rs; alu_zero = v.zero;
  endtask

  initial begin
    // Each row: inputs for one cycle and the pc/redirect observed before that cycle's edge.
    //             rst   stl   vld   typ     br_pc         imm       idx          rs            z     exp_pc        rd
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_3000, 16'h0000, 26'h0000100, 32'h0,        1'b0, 32'h0000_3000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3004, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3008, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_300C, 1'b0));
    // beq taken, then beq not taken
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_3004, 16'h0003, 26'h0,       32'h0,        1'b1, 32'h0000_3010, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3014, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_3004, 16'h0003, 26'h0,       32'h0,        1'b0, 32'h0000_3018, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_301C, 1'b0));
    // bne negative offset taken, then not taken
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_3010, 16'hFFFE, 26'h0,       32'h0,        1'b0, 32'h0000_3020, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_3010, 16'hFFFE, 26'h0,       32'h0,        1'b1, 32'h0000_300C, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3010, 1'b0));
    // jal under a 3-cycle stall; a j during PENDING is ignored
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b100, 32'h0000_3020, 16'h0000, 26'h0000C10, 32'h0,        1'b0, 32'h0000_3014, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b011, 32'h0000_3024, 16'h0000, 26'h0000100, 32'h0,        1'b0, 32'h0000_3014, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3014, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3014, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b011, 32'h0000_3040, 16'h0000, 26'h0000100, 32'h0,        1'b0, 32'h0000_3040, 1'b1));
    // enter PENDING then reset: pending target must be discarded
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0400, 16'h0001, 26'h0,       32'h0,        1'b1, 32'h0000_0400, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_0400, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b101, 32'h0000_3004, 16'h0000, 26'h0,       32'h0000_3008, 1'b0, 32'h0000_3004, 1'b1));
    // beq target wraps past 2^32
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b001, 32'hFFFF_FFF8, 16'h0004, 26'h0,       32'h0,        1'b1, 32'h0000_3008, 1'b1));
    // reserved br_type is not a transfer
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'b110, 32'h0000_0010, 16'h0000, 26'h0000100, 32'h0,        1'b1, 32'h0000_000C, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_0010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_0010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_0014, 1'b0));

    apply(mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0));
    @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check32($sformatf("v%0d.pc", i), pc, vecs[i].exp_pc);
      check1($sformatf("v%0d.redirect", i), redirect, vecs[i].exp_redir);
      check32($sformatf("v%0d.pc_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      check32($sformatf("v%0d.link_addr", i), link_addr, vecs[i].bpc + 32'd8);
      check1($sformatf("v%0d.misalign", i), misalign, 1'b0);
    end

    // Hand sequence: misaligned jr from pc 0x18.
    @(negedge clk);
    apply(mk(1'b0, 1'b0, 1'b1, 3'b101, 32'h0000_0018, 16'h0, 26'h0, 32'h0000_3002, 1'b0, 32'h0, 1'b0));
    #1;
    check32("jr.pc", pc, 32'h0000_0018);
    check1("jr.redirect", redirect, 1'b1);
`ifdef MISALIGN_CHECK_EN
    check1("jr.misalign", misalign, 1'b1);
`else
    check1("jr.misalign", misalign, 1'b0);
`endif
    @(negedge clk);
    apply(mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0));
    #1;
`ifdef MISALIGN_CHECK_EN
    check32("jr.next_pc", pc, 32'h0000_4180);
`else
    check32("jr.next_pc", pc, 32'h0000_3000);
`endif
    check1("jr.misalign_after", misalign, 1'b0);
    @(negedge clk);
    #1;
`ifdef MISALIGN_CHECK_EN
    check32("jr.pc_plus_1", pc, 32'h0000_4184);
`else
    check32("jr.pc_plus_1", pc, 32'h0000_3004);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npc_pc_unit.md
Name: npc_pc_unit

Overview:
- Program-counter register plus next-PC/branch-resolution unit for the 5-stage MIPS pipeline.
- Consumes the EX-stage ALU Zero flag together with branch/jump decode info, and computes taken/not-taken and the target.
- Drives the IF-stage PC and signals a redirect to the hazard unit.
- Buffers one resolved redirect if IF is stalled, so no taken branch is lost.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on a misaligned jr (only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  IF stall from the hazard unit; PC holds while high.
- br_valid  input  1  an EX-stage control-transfer instruction is valid this cycle.
- br_type  input  3  000 none, 001 beq, 010 bne, 011 j, 100 jal, 101 jr; others are treated as none.
- br_pc  input  32  PC of the EX-stage instruction.
- imm16  input  16  branch offset field.
- instr_index  input  26  j/jal index field.
- rs_val  input  32  forwarded rs value for jr.
- alu_zero  input  1  Zero flag from the ALU (A==B).
- pc  output  32  current fetch PC.
- pc_plus4  output  32  pc+4, combinational.
- link_addr  output  32  br_pc+8, combinational (delay-slot convention), for jal.
- redirect  output  1  a taken transfer was resolved this cycle; the hazard unit flushes younger-than-delay-slot instructions.
- misalign  output  1  one-cycle pulse on a misaligned jr target (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: synchronous, active-high.
  - pc=RESET_PC, state=IDLE, pending target cleared, misalign=0.
  - redirect is combinational but forced 0 while reset is high.
- Taken condition, evaluated only when br_valid=1 and state=IDLE:
  - beq: alu_zero=1.
  - bne: alu_zero=0.
  - j, jal, jr: always taken.
- Targets, with all arithmetic modulo 2^32 (wrap-around allowed, no overflow flag):
  - beq/bne: br_pc+4+(sign_extend(imm16)<<2).
  - j/jal: {br_pc_plus4[31:28], instr_index, 2'b00}.
  - jr: rs_val.
- redirect = br_valid & taken & (state==IDLE) & ~reset.
- FSM, two states: IDLE and PENDING.
  - IDLE, taken, stall=0: pc<=target next edge; stay IDLE.
  - IDLE, taken, stall=1: latch target into pend_pc; go to PENDING; pc holds.
  - IDLE, not taken or no branch: if stall=0, pc<=pc+4; else hold.
  - PENDING, stall=1: hold pc and pend_pc.
  - PENDING, stall=0: pc<=pend_pc; go to IDLE.
  - PENDING: br_valid is ignored (the younger instruction is flushed); redirect stays 0.
- Latency:
  - Taken transfer with no stall: target appears on pc exactly 1 cycle after resolution.
  - With stall: target appears 1 cycle after stall deasserts.
- Reset mid-PENDING: pending target discarded, pc=RESET_PC.
- Reset has priority over stall and branches.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined: a taken jr with rs_val[1:0]!=2'b00 uses EXC_VECTOR as its target (through the same IDLE/PENDING path) and pulses misalign=1 for the resolving cycle.
- Undefined: the jr target is {rs_val[31:2],2'b00}; misalign is constant 0.

Decomposition:
- Shared package (mips_pkg), holding:
  - br_type encodings (BR_NONE, BR_BEQ, BR_BNE, BR_J, BR_JAL, BR_JR).
  - RESET_PC and EXC_VECTOR defaults.
  - FSM state encodings.
- One combinational sub-module, npc_target: computes taken and target from br_type, br_pc, imm16, instr_index, rs_val and alu_zero.
- The top holds the PC register, the FSM and pend_pc.

Test Plan:
- Reset, then stall=0 and no branches for 3 cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C.
- beq, br_pc=0x3004, imm16=0x0003, alu_zero=1 -> redirect=1 that cycle; next pc=0x3014. Same with alu_zero=0 -> redirect=0; pc+4 continues.
- bne, imm16=0xFFFE, br_pc=0x3010, alu_zero=0 -> next pc=0x300C (negative offset). With alu_zero=1 -> not taken.
- jal, instr_index=0x0000C10, br_pc=0x3020, stall=1 for 3 cycles -> link_addr=0x3028; pc holds 3 cycles; pc=0x3040 one cycle after stall drops. A second br_valid during PENDING is ignored.
- Reset asserted while PENDING -> pc=0x3000 next edge; pending target not applied after reset releases.
- jr, rs_val=0x00003002, with MISALIGN_CHECK_EN -> misalign=1 one cycle; next pc=0x4180. Without the macro -> next pc=0x3000; misalign=0.
